// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// State encoding, opcode-size bit and default jump opcode.
package fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        RESET_PC,
        FETCH,
        FETCH_ARG,
        JUMP,
        ISSUE,
        REDIRECT
    } fs_state_t;

    localparam int TWO_BYTE_BIT = 7;
    localparam logic [7:0] DEFAULT_JMP_OP = 8'hF0;
    localparam logic [7:0] DEFAULT_RESET_VEC = 8'h00;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch controller: steers pcCounter, reads 1/2-byte instructions,
// resolves unconditional jumps and hands instructions to decode.
import fetch_sequencer_pkg::*;

module fetch_sequencer #(
    parameter logic [7:0] RESET_VEC = DEFAULT_RESET_VEC,
    parameter logic [7:0] JMP_OP    = DEFAULT_JMP_OP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] PC,
    output logic [7:0] PC_load,
    output logic       PC_en,
    output logic       PC_inc,
    output logic [7:0] mem_addr,
    output logic       mem_req,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] instr,
    output logic [7:0] operand,
    input  logic       redirect_en,
    input  logic [7:0] redirect_target
);

    fs_state_t  state;
    logic       pend;
    logic [7:0] tgt;
    logic       divert;

    assign divert      = pend | redirect_en;
    assign mem_addr    = PC;
    assign mem_req     = (state == FETCH) || (state == FETCH_ARG);
    assign instr_valid = (state == ISSUE);

    // Counter control is decoded from state plus mem_ack so the PC
    // steps on the very edge that consumes a byte.
    always_comb begin
        PC_en   = 1'b0;
        PC_inc  = 1'b0;
        PC_load = RESET_VEC;
        if (!rst) begin
            unique case (state)
                RESET_PC: PC_en = 1'b1;
                JUMP: begin
                    PC_en   = 1'b1;
                    PC_load = operand;
                end
                REDIRECT: begin
                    PC_en   = 1'b1;
                    PC_load = tgt;
                end
                FETCH, FETCH_ARG: begin
                    PC_en  = mem_ack & ~pend;
                    PC_inc = mem_ack & ~pend;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RESET_PC;
            instr   <= 8'h00;
            operand <= 8'h00;
            pend    <= 1'b0;
            tgt     <= 8'h00;
        end else begin
            if (redirect_en) begin
                pend <= 1'b1;
                tgt  <= redirect_target;
            end
            unique case (state)
                RESET_PC: state <= divert ? REDIRECT : FETCH;
                FETCH: begin
                    if (mem_ack) begin
                        if (divert) begin
                            state <= REDIRECT;
                        end else begin
                            instr <= mem_rdata;
                            if (mem_rdata[TWO_BYTE_BIT]) begin
                                state <= FETCH_ARG;
                            end else begin
                                operand <= 8'h00;
                                state   <= ISSUE;
                            end
                        end
                    end
                end
                FETCH_ARG: begin
                    if (mem_ack) begin
                        if (divert) begin
                            state <= REDIRECT;
                        end else begin
                            operand <= mem_rdata;
                            state   <= (instr == JMP_OP) ? JUMP : ISSUE;
                        end
                    end
                end
                JUMP: state <= divert ? REDIRECT : FETCH;
                ISSUE: begin
                    if (divert)
                        state <= REDIRECT;
                    else if (instr_ready)
                        state <= FETCH;
                end
                REDIRECT: begin
                    // A redirect landing here re-arms and reloads once more.
                    pend  <= redirect_en;
                    state <= redirect_en ? REDIRECT : FETCH;
                end
                default: state <= RESET_PC;
            endcase
        end
    end

endmodule
